// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port (CPU / DMA) data-memory arbiter, 3-cycle transactions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [10:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [10:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        dm_cs,
    output logic        dm_r,
    output logic        dm_w,
    output logic        dm_sb,
    output logic        dm_sh,
    output logic [10:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_wait_cnt;
    logic        r_id;
    logic        r_we;
    logic [1:0]  r_size;
    logic [10:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        w_any_req;
    logic        w_grant_m1;

    assign w_any_req  = m0_req | m1_req;
    // m1 is forced through once m0 has been granted STARVE_LIMIT times in a row
    assign w_grant_m1 = m1_req & (~m0_req | (32'(r_wait_cnt) >= STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:   w_next_state = w_any_req ? S_ACCESS : S_IDLE;
            S_ACCESS: w_next_state = S_ACK;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        dm_cs  = 1'b0;
        dm_r   = 1'b0;
        dm_w   = 1'b0;
        dm_sb  = 1'b0;
        dm_sh  = 1'b0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        if (r_state == S_ACCESS) begin
            dm_cs = 1'b1;
            dm_r  = ~r_we;
            dm_w  = r_we;
            dm_sb = r_we & (r_size == 2'b10);
            dm_sh = r_we & (r_size == 2'b01);
        end
        if (r_state == S_ACK) begin
            m0_ack = ~r_id;
            m1_ack = r_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 3'd0;
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 11'd0;
            r_wdata    <= 32'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_grant_m1 || !m1_req) begin
                    r_wait_cnt <= 3'd0;
                end else if (r_wait_cnt != 3'd7) begin
                    r_wait_cnt <= r_wait_cnt + 3'd1;
                end
                if (w_any_req) begin
                    r_id    <= w_grant_m1;
                    r_we    <= w_grant_m1 ? m1_we    : m0_we;
                    r_size  <= w_grant_m1 ? m1_size  : m0_size;
                    r_addr  <= w_grant_m1 ? m1_addr  : m0_addr;
                    r_wdata <= w_grant_m1 ? m1_wdata : m0_wdata;
                end
            end
            if (r_state == S_ACCESS && !r_we) begin
                if (r_id) begin
                    r_m1_rdata <= dm_rdata;
                end else begin
                    r_m0_rdata <= dm_rdata;
                end
            end
        end
    end

    assign dm_addr  = r_addr;
    assign dm_wdata = r_wdata;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, number of consecutive m0 grants tolerated while m1 waits before m1 is forced.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0_req  input  1  CPU port access request, held until m0_ack.
REQ-005 m0_we  input  1  CPU port: 1 = store, 0 = load.
REQ-006 m0_size  input  2  CPU port: 00 word, 01 half, 10 byte, 11 word.
REQ-007 m0_addr  input  11  CPU port word address.
REQ-008 m0_wdata  input  32  CPU port store data.
REQ-009 m0_ack  output  1  CPU port one-cycle completion pulse.
REQ-010 m0_rdata  output  32  CPU port load data, valid while m0_ack=1.
REQ-011 m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_ack, m1_rdata: DMA/loader port, identical widths and meaning to m0.
REQ-012 dm_cs  output  1  memory chip select.
REQ-013 dm_r  output  1  memory read enable.
REQ-014 dm_w  output  1  memory write enable.
REQ-015 dm_sb  output  1  memory byte-store select.
REQ-016 dm_sh  output  1  memory halfword-store select.
REQ-017 dm_addr  output  11  memory word address.
REQ-018 dm_wdata  output  32  store data to memory.
REQ-019 dm_rdata  input  32  load data from memory, combinational on dm_addr when dm_r=1.

Function
REQ-020 FSM states IDLE, ACCESS, ACK; exactly one memory access per transaction; transaction = 3 cycles.
REQ-021 IDLE: if no req, stay IDLE; if any req, select winner, latch winner id, we, size, addr, wdata into command registers, go ACCESS.
REQ-022 Arbitration: m0 wins when both request, unless wait_cnt >= STARVE_LIMIT, then m1 wins; single requester always wins.
REQ-023 wait_cnt (3 bits, saturating at 7): +1 on each IDLE decision granting m0 while m1_req=1; cleared when m1 granted or when m1_req=0 in IDLE.
REQ-024 ACCESS: dm_cs=1, dm_addr/dm_wdata from command registers, dm_w=we, dm_r=~we, dm_sb=we&(size==10), dm_sh=we&(size==01); go ACK.
REQ-025 ACCESS load: capture dm_rdata into winner's rdata register at end of cycle; store: rdata register unchanged.
REQ-026 ACK: winner's ack=1 for exactly this cycle, other ack=0, all dm_* controls 0; go IDLE unconditionally.
REQ-027 Requests sampled only in IDLE; req changes during ACCESS/ACK ignored; requester drops or renews req in cycle after ack.
REQ-028 Outside ACCESS: dm_cs, dm_r, dm_w, dm_sb, dm_sh = 0; dm_addr and dm_wdata hold command registers.
REQ-029 Load data is full 32-bit word regardless of size; byte/half extraction is requester's job.
REQ-030 m0_rdata/m1_rdata hold last loaded value until next load for that port.
REQ-031 Never both acks high in one cycle; never dm_r and dm_w both high.

Reset
REQ-032 rst_n=0 asynchronously forces: state IDLE, wait_cnt 0, command registers 0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, all dm_* outputs 0.
REQ-033 Reset asserted during ACCESS drops dm_cs/dm_w immediately without waiting for clk; the pending transaction is discarded and never acked.
REQ-034 First arbitration occurs on the first posedge after rst_n deasserts.

Verification
REQ-035 m0 load addr 0x010, memory holds 0x DEADBEEF -> dm_cs=dm_r=1 in cycle 2, m0_ack=1 and m0_rdata=0xDEADBEEF in cycle 3.
REQ-036 m1 store byte addr 0x7FF, wdata 0x000000A5 -> ACCESS cycle shows dm_w=1, dm_sb=1, dm_sh=0, dm_addr=0x7FF; m1_ack in ACK cycle; subsequent load returns low byte 0xA5 with upper bytes unchanged.
REQ-037 m0 and m1 requesting continuously, STARVE_LIMIT=4 -> grant sequence m0,m0,m0,m0,m1, repeating; wait_cnt returns 0 after each m1 grant.
REQ-038 Simultaneous first request from both ports after reset -> m0 granted first, m1 granted next transaction.
REQ-039 rst_n pulsed low mid-ACCESS of an m0 store -> dm_w falls asynchronously, no m0_ack, memory unchanged, state IDLE after release.
REQ-040 m0 halfword store then m0 word load same addr -> dm_sh=1 on store only; load returns merged word; acks spaced 3 cycles apart.
